// File: rtl/wb_downsize_seq_pkg.sv
// Shared Wishbone definitions for the 32-to-8 bit sequencing width converter:
// FSM encoding, constant cycle-type values and the big-endian lane map.
package wb_downsize_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    // Big-endian map: lane 3 (dat[31:24]) lives at byte offset 0.
    function automatic logic [1:0] lane_to_offset(input logic [1:0] lane);
        return 2'd3 - lane;
    endfunction

endpackage

// File: rtl/wb_downsize_seq_if.sv
// Classic Wishbone bus bundle, parameterised by address and data width.
// Signal direction names are from the master's point of view (dat_w out, dat_r in).
interface wb_downsize_seq_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic [SW-1:0] sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic          err;
    logic          rty;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err, rty
    );

endinterface

// File: rtl/wb_downsize_seq.sv
// Splits each 32-bit Wishbone access into one 8-bit slave cycle per selected
// lane, highest lane first, and returns a single ack/err/rty to the master.
module wb_downsize_seq
    import wb_downsize_seq_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_downsize_seq_if.slave  wbm,
    wb_downsize_seq_if.master wbs
);

    function automatic logic [1:0] highest_lane(input logic [3:0] mask);
        if (mask[3])      return 2'd3;
        else if (mask[2]) return 2'd2;
        else if (mask[1]) return 2'd1;
        else              return 2'd0;
    endfunction

    state_t        r_state;
    logic [AW-3:0] r_adr;
    logic [31:0]   r_dat;
    logic          r_we;
    logic [3:0]    r_pend;
    logic [31:0]   r_rdat;

    logic [31:0]   r_wbm_dat;
    logic          r_wbm_ack;
    logic          r_wbm_err;
    logic          r_wbm_rty;
    logic [AW-1:0] r_wbs_adr;
    logic [7:0]    r_wbs_dat;
    logic          r_wbs_we;
    logic          r_wbs_cyc;

    logic [1:0]    w_lane;
    logic [3:0]    w_pend_next;
    logic [1:0]    w_lane_next;
    logic [1:0]    w_req_lane;
    logic [31:0]   w_rdat_next;
    logic          w_unused;

    assign w_lane      = highest_lane(r_pend);
    assign w_pend_next = r_pend & ~(4'b0001 << w_lane);
    assign w_lane_next = highest_lane(w_pend_next);
    assign w_req_lane  = highest_lane(wbm.sel);

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_rdat_next = r_rdat;
        if (!r_we) begin
            w_rdat_next[{w_lane, 3'b000} +: 8] = wbs.dat_r;
        end
    end

    // NOTE: all FSM state and outputs use non-blocking assignments and are cleared by the async reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_adr     <= '0;
            r_dat     <= '0;
            r_we      <= 1'b0;
            r_pend    <= '0;
            r_rdat    <= '0;
            r_wbm_dat <= '0;
            r_wbm_ack <= 1'b0;
            r_wbm_err <= 1'b0;
            r_wbm_rty <= 1'b0;
            r_wbs_adr <= '0;
            r_wbs_dat <= '0;
            r_wbs_we  <= 1'b0;
            r_wbs_cyc <= 1'b0;
        end else begin
            r_wbm_ack <= 1'b0;
            r_wbm_err <= 1'b0;
            r_wbm_rty <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wbm_dat <= '0;
                    if (wbm.cyc && wbm.stb) begin
                        r_adr  <= wbm.adr[AW-1:2];
                        r_dat  <= wbm.dat_w;
                        r_we   <= wbm.we;
                        r_pend <= wbm.sel;
                        r_rdat <= '0;
                        if (wbm.sel != 4'b0000) begin
                            r_state   <= ST_ACCESS;
                            r_wbs_cyc <= 1'b1;
                            r_wbs_we  <= wbm.we;
                            r_wbs_adr <= {wbm.adr[AW-1:2], lane_to_offset(w_req_lane)};
                            r_wbs_dat <= wbm.dat_w[{w_req_lane, 3'b000} +: 8];
                        end else begin
                            r_state   <= ST_DONE;
                            r_wbm_ack <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!wbm.cyc) begin
                        r_state   <= ST_IDLE;
                        r_wbs_cyc <= 1'b0;
                        r_wbs_we  <= 1'b0;
                    end else if (wbs.err || wbs.rty) begin
                        // err outranks rty; any ack in this cycle is discarded.
                        r_state   <= ST_DONE;
                        r_wbm_err <= wbs.err;
                        r_wbm_rty <= !wbs.err;
                        r_wbm_dat <= r_rdat;
                        r_wbs_cyc <= 1'b0;
                        r_wbs_we  <= 1'b0;
                    end else if (wbs.ack) begin
                        r_rdat <= w_rdat_next;
                        r_pend <= w_pend_next;
                        if (w_pend_next == 4'b0000) begin
                            r_state   <= ST_DONE;
                            r_wbm_ack <= 1'b1;
                            r_wbm_dat <= w_rdat_next;
                            r_wbs_cyc <= 1'b0;
                            r_wbs_we  <= 1'b0;
                        end else begin
                            r_wbs_adr <= {r_adr, lane_to_offset(w_lane_next)};
                            r_wbs_dat <= r_dat[{w_lane_next, 3'b000} +: 8];
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_wbm_dat <= '0;
                end
            endcase
        end
    end

    assign wbm.dat_r = r_wbm_dat;
    assign wbm.ack   = r_wbm_ack;
    assign wbm.err   = r_wbm_err;
    assign wbm.rty   = r_wbm_rty;

    assign wbs.adr   = r_wbs_adr;
    assign wbs.dat_w = r_wbs_dat;
    assign wbs.sel   = '1;
    assign wbs.we    = r_wbs_we;
    assign wbs.cyc   = r_wbs_cyc;
    assign wbs.stb   = r_wbs_cyc;
    assign wbs.cti   = WB_CTI_CLASSIC;
    assign wbs.bte   = WB_BTE_LINEAR;

    // Burst type info and the byte-address bits are accepted but carry no meaning here.
    assign w_unused = ^{wbm.cti, wbm.bte, wbm.adr[1:0]};

endmodule

// File: tb/tb_wb_downsize_seq.sv
// Directed bench for wb_downsize_seq: a byte-wide slave model with programmable
// wait states, read bytes and error injection, plus hand-computed expectations.
module tb_wb_downsize_seq;

    logic clk;
    logic rst;

    wb_downsize_seq_if #(.AW(32), .DW(32)) wbm_bus ();
    wb_downsize_seq_if #(.AW(32), .DW(8))  wbs_bus ();

    wb_downsize_seq #(.AW(32)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbm      (wbm_bus),
        .wbs      (wbs_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Slave model configuration, written only by the stimulus process.
    int         waits;
    int         err_idx;
    int         base;
    logic [7:0] rd_bytes [8];

    // Slave model state, written only by the clocked process.
    int          wcnt;
    int          s_idx;
    int          cyc_cnt;
    logic [31:0] log_adr [$];
    logic [7:0]  log_dat [$];
    logic        log_we  [$];

    always_comb begin
        wbs_bus.ack   = 1'b0;
        wbs_bus.err   = 1'b0;
        wbs_bus.rty   = 1'b0;
        wbs_bus.dat_r = 8'h00;
        if (wbs_bus.cyc && wbs_bus.stb && wcnt == waits) begin
            if (s_idx - base == err_idx) wbs_bus.err = 1'b1;
            else                         wbs_bus.ack = 1'b1;
            wbs_bus.dat_r = rd_bytes[(s_idx - base) & 7];
        end
    end

    initial begin
        wcnt    = 0;
        s_idx   = 0;
        cyc_cnt = 0;
    end

    always @(posedge clk) begin
        if (wbs_bus.cyc) cyc_cnt <= cyc_cnt + 1;
        if (wbs_bus.cyc && wbs_bus.stb) begin
            if (wbs_bus.ack || wbs_bus.err || wbs_bus.rty) begin
                log_adr.push_back(wbs_bus.adr);
                log_dat.push_back(wbs_bus.dat_w);
                log_we.push_back(wbs_bus.we);
                s_idx <= s_idx + 1;
                wcnt  <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    task automatic drive_req(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we);
        base          = s_idx;
        wbm_bus.adr   = adr;
        wbm_bus.dat_w = dat;
        wbm_bus.sel   = sel;
        wbm_bus.we    = we;
        wbm_bus.cyc   = 1'b1;
        wbm_bus.stb   = 1'b1;
    endtask

    task automatic drop_req();
        wbm_bus.cyc = 1'b0;
        wbm_bus.stb = 1'b0;
        wbm_bus.we  = 1'b0;
    endtask

    // Called at a negedge; returns the cycle (request edge = cycle 0) of termination.
    task automatic run_xact(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we,
                            output int cyc_n, output logic [2:0] term,
                            output logic [31:0] rdat);
        drive_req(adr, dat, sel, we);
        cyc_n = -1;
        term  = 3'b000;
        rdat  = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (wbm_bus.ack || wbm_bus.err || wbm_bus.rty) begin
                cyc_n = c;
                term  = {wbm_bus.ack, wbm_bus.err, wbm_bus.rty};
                rdat  = wbm_bus.dat_r;
                break;
            end
        end
        drop_req();
        if (cyc_n < 0) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mdat"}, wbm_bus.dat_r, 32'h0);
        check({tag, "_mterm"}, {29'd0, wbm_bus.ack, wbm_bus.err, wbm_bus.rty}, 32'h0);
        check({tag, "_sadr"}, wbs_bus.adr, 32'h0);
        check({tag, "_sctl"}, {27'd0, wbs_bus.dat_w == 8'h00, wbs_bus.we,
                               wbs_bus.cyc, wbs_bus.stb, 1'b0}, 32'h10);
    endtask

    int          cyc_n;
    logic [2:0]  term;
    logic [31:0] rdat;
    int          cnt0;

    initial begin
        rst     = 1'b1;
        waits   = 0;
        err_idx = -1;
        for (int i = 0; i < 8; i++) rd_bytes[i] = 8'h00;
        wbm_bus.adr   = '0;
        wbm_bus.dat_w = '0;
        wbm_bus.sel   = '0;
        wbm_bus.we    = 1'b0;
        wbm_bus.cyc   = 1'b0;
        wbm_bus.stb   = 1'b0;
        wbm_bus.cti   = 3'b000;
        wbm_bus.bte   = 2'b00;
        base          = 0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_cti_bte", {27'd0, wbs_bus.cti, wbs_bus.bte}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 32-bit write, zero-wait slave.
        run_xact(32'h0000_0100, 32'h1122_3344, 4'b1111, 1'b1, cyc_n, term, rdat);
        check("w32_cycle", cyc_n, 32'd5);
        check("w32_term", {29'd0, term}, 32'h4);
        check("w32_count", s_idx - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w32_adr%0d", i), log_adr[base + i], 32'h100 + i);
            check($sformatf("w32_dat%0d", i), {24'd0, log_dat[base + i]}, 32'h11 * (i + 1));
            check($sformatf("w32_we%0d", i), {31'd0, log_we[base + i]}, 32'd1);
        end
        @(negedge clk);
        check("w32_idle_dat", wbm_bus.dat_r, 32'h0);

        // 16-bit read of the low half-word.
        rd_bytes[0] = 8'hAB;
        rd_bytes[1] = 8'hCD;
        run_xact(32'h0000_0100, 32'h0, 4'b0011, 1'b0, cyc_n, term, rdat);
        check("r16_cycle", cyc_n, 32'd3);
        check("r16_term", {29'd0, term}, 32'h4);
        check("r16_data", rdat, 32'h0000_ABCD);
        check("r16_adr0", log_adr[base], 32'h102);
        check("r16_adr1", log_adr[base + 1], 32'h103);
        check("r16_we", {31'd0, log_we[base]}, 32'd0);
        @(negedge clk);

        // Sparse read with two wait states per byte.
        waits       = 2;
        rd_bytes[0] = 8'h5A;
        rd_bytes[1] = 8'hA5;
        run_xact(32'h0000_0200, 32'h0, 4'b1001, 1'b0, cyc_n, term, rdat);
        check("sp_cycle", cyc_n, 32'd7);
        check("sp_data", rdat, 32'h5A00_00A5);
        check("sp_count", s_idx - base, 32'd2);
        check("sp_adr0", log_adr[base], 32'h200);
        check("sp_adr1", log_adr[base + 1], 32'h203);
        waits = 0;
        @(negedge clk);

        // Error on the second byte of a 32-bit write.
        err_idx = 1;
        run_xact(32'h0000_0100, 32'h1122_3344, 4'b1111, 1'b1, cyc_n, term, rdat);
        check("err_cycle", cyc_n, 32'd3);
        check("err_term", {29'd0, term}, 32'h2);
        check("err_count", s_idx - base, 32'd2);
        @(negedge clk);
        check("err_count_after", s_idx - base, 32'd2);
        check("err_scyc_after", {31'd0, wbs_bus.cyc}, 32'd0);
        err_idx = -1;

        // Empty select: immediate ack, no slave cycle.
        cnt0 = cyc_cnt;
        run_xact(32'h0000_0400, 32'hDEAD_BEEF, 4'b0000, 1'b0, cyc_n, term, rdat);
        check("sel0_cycle", cyc_n, 32'd1);
        check("sel0_term", {29'd0, term}, 32'h4);
        check("sel0_data", rdat, 32'h0);
        @(negedge clk);
        check("sel0_no_cyc", cyc_cnt - cnt0, 32'd0);

        // Master abandons the cycle mid-sequence.
        waits = 5;
        drive_req(32'h0000_0100, 32'h1122_3344, 4'b1111, 1'b1);
        @(negedge clk);
        check("drop_scyc_on", {31'd0, wbs_bus.cyc}, 32'd1);
        drop_req();
        @(negedge clk);
        check("drop_scyc_off", {30'd0, wbs_bus.cyc, wbs_bus.stb}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("drop_noterm%0d", i),
                  {29'd0, wbm_bus.ack, wbm_bus.err, wbm_bus.rty}, 32'h0);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of an access.
        drive_req(32'h0000_0100, 32'h0, 4'b1111, 1'b0);
        @(negedge clk);
        check("rst_pre_cyc", {31'd0, wbs_bus.cyc}, 32'd1);
        #2 rst = 1'b1;
        #1 check_idle_outputs("rst_mid");
        @(negedge clk);
        drop_req();
        rst = 1'b0;
        @(negedge clk);
        check("rst_noacc", s_idx - base, 32'd0);
        waits       = 0;
        rd_bytes[0] = 8'h77;
        run_xact(32'h0000_0300, 32'h0, 4'b0100, 1'b0, cyc_n, term, rdat);
        check("b8_cycle", cyc_n, 32'd2);
        check("b8_term", {29'd0, term}, 32'h4);
        check("b8_data", rdat, 32'h0077_0000);
        check("b8_adr", log_adr[base], 32'h301);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
